// File: rtl/hilo_muldiv_pkg.sv
// hilo_pkg: shared types and op-class helpers for the HI/LO multiply/divide unit.
//   hilo_op_e    - 4-bit operation code presented with each request
//   hilo_state_e - control FSM state encoding
package hilo_pkg;

  typedef enum logic [3:0] {
    OP_MTHI,
    OP_MTLO,
    OP_MFHI,
    OP_MFLO,
    OP_DIV,
    OP_DIVU,
    OP_MULT,
    OP_MULTU,
    OP_MUL,
    OP_MADD,
    OP_MADDU,
    OP_MSUB,
    OP_MSUBU
  } hilo_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } hilo_state_e;

  function automatic logic is_signed_op(input hilo_op_e op);
    return op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB, OP_DIV};
  endfunction

  function automatic logic is_mul_op(input hilo_op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div_op(input hilo_op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  // True for ops that update at least one of HI/LO on commit.
  function automatic logic writes_hilo(input hilo_op_e op);
    return op inside {OP_MTHI, OP_MTLO, OP_DIV, OP_DIVU, OP_MULT, OP_MULTU,
                      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// div_iter: restoring radix-2 divider on unsigned magnitudes, one quotient bit
// per cycle. Operands are captured on start; done rises XLEN cycles later and
// stays high until the next start or an abort.
//   clk, reset          - clock, synchronous active-high reset
//   abort               - drop the division in progress
//   start               - load dividend/divisor and begin
//   dividend, divisor   - magnitudes
//   busy, done          - iterating / result valid
//   quotient, remainder - unsigned result
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo, rem, dvs;
  logic [XLEN:0]   shifted, diff;

  // Partial remainder always stays below the divisor, so XLEN+1 bits suffice.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      done <= 1'b0;
      cnt  <= CW'(XLEN);
      quo  <= dividend;
      rem  <= '0;
      dvs  <= divisor;
    end else if (busy) begin
      if (diff[XLEN]) begin
        rem <= shifted[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end else begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative HI/LO multiply/divide unit. One operation at a time
// through in_valid/in_ready; result through out_valid/out_ready. HI/LO are
// committed only on the output handshake (unless wr_disable or flush).
//   clk, reset                - clock, synchronous active-high reset
//   flush                     - abort anything in flight, no commit
//   in_valid, in_ready        - request handshake; op, src1, src2 operands
//   out_valid, out_ready      - result handshake; result is the GPR value
//   wr_disable                - suppress the HI/LO commit at the handshake
//   hi, lo                    - architectural HI/LO registers
//
// state   | meaning
// IDLE    | ready for a new op
// MUL     | product travelling down the multiply pipe
// DIV     | divider iterating
// DONE    | result held on out_valid until consumed
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  hilo_op_e        op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            wr_disable,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int W2 = 2 * XLEN;
  localparam int PD = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

  hilo_state_e     state, state_nxt;
  hilo_op_e        op_q;
  logic [XLEN-1:0] src1_q, src2_q, result_q, pend_hi, pend_lo;
  logic            hi_we, lo_we;
  logic            accept, commit;

  logic            div_busy, div_done, div_fin;
  logic [XLEN-1:0] div_q, div_r, q_fix, r_fix;

  logic            mul_fin;
  hilo_op_e        mul_op;
  logic [W2-1:0]   mul_src, mul_prod, mul_val;

  function automatic logic [W2-1:0] ext(input logic [XLEN-1:0] v, input logic sgn);
    return {{XLEN{sgn & v[XLEN-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  // Divider busy is always low in IDLE; folding it in keeps in_ready honest.
  assign in_ready  = (state == ST_IDLE) && !div_busy;
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign commit    = out_valid && out_ready && !flush && !wr_disable;
  assign result    = result_q;

  // Product of the operands as presented; the pipe below only delays it.
  assign mul_src = ext(src1, is_signed_op(op)) * ext(src2, is_signed_op(op));

  generate
    if (MUL_STAGES == 1) begin : g_mul_single
      assign mul_fin  = accept && is_mul_op(op);
      assign mul_prod = mul_src;
      assign mul_op   = op;
    end else begin : g_mul_pipe
      logic [W2-1:0] prod_pipe [PD];
      logic [PD-1:0] prod_v;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          prod_v <= '0;
        end else begin
          prod_v[0] <= accept && is_mul_op(op);
          for (int i = 1; i < PD; i++) prod_v[i] <= prod_v[i-1];
        end
      end

      always_ff @(posedge clk) begin
        prod_pipe[0] <= mul_src;
        for (int i = 1; i < PD; i++) prod_pipe[i] <= prod_pipe[i-1];
      end

      assign mul_fin  = (state == ST_MUL) && prod_v[PD-1];
      assign mul_prod = prod_pipe[PD-1];
      assign mul_op   = op_q;
    end
  endgenerate

  always_comb begin
    mul_val = mul_prod;
    if (mul_op inside {OP_MADD, OP_MADDU}) mul_val = {hi, lo} + mul_prod;
    else if (mul_op inside {OP_MSUB, OP_MSUBU}) mul_val = {hi, lo} - mul_prod;
  end

  // Magnitudes are formed from the live operands so iteration starts at accept.
  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .abort     (flush),
    .start     (accept && is_div_op(op)),
    .dividend  (magnitude(src1, is_signed_op(op))),
    .divisor   (magnitude(src2, is_signed_op(op))),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign div_fin = (state == ST_DIV) && div_done;

  always_comb begin
    q_fix = div_q;
    r_fix = div_r;
    if (src2_q == '0) begin
      q_fix = '1;
      r_fix = src1_q;
    end else if (is_signed_op(op_q)) begin
      if (src1_q[XLEN-1] ^ src2_q[XLEN-1]) q_fix = -div_q;
      if (src1_q[XLEN-1]) r_fix = -div_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) begin
          if (is_mul_op(op))      state_nxt = (MUL_STAGES == 1) ? ST_DONE : ST_MUL;
          else if (is_div_op(op)) state_nxt = ST_DIV;
          else                    state_nxt = ST_DONE;
        end
        ST_MUL:  if (mul_fin) state_nxt = ST_DONE;
        ST_DIV:  if (div_fin) state_nxt = ST_DONE;
        ST_DONE: if (out_ready) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_MTHI;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
      pend_hi  <= '0;
      pend_lo  <= '0;
      hi_we    <= 1'b0;
      lo_we    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      if (accept) begin
        op_q   <= op;
        src1_q <= src1;
        src2_q <= src2;
        if (!is_mul_op(op) && !is_div_op(op)) begin
          hi_we   <= writes_hilo(op) && (op != OP_MTLO);
          lo_we   <= writes_hilo(op) && (op != OP_MTHI);
          pend_hi <= src1;
          pend_lo <= src1;
          case (op)
            OP_MFHI: result_q <= hi;
            OP_MFLO: result_q <= lo;
            default: result_q <= src1;
          endcase
        end
      end
      if (mul_fin) begin
        result_q           <= mul_val[XLEN-1:0];
        {pend_hi, pend_lo} <= mul_val;
        hi_we              <= writes_hilo(mul_op);
        lo_we              <= writes_hilo(mul_op);
      end
      if (div_fin) begin
        result_q <= q_fix;
        pend_lo  <= q_fix;
        pend_hi  <= r_fix;
        hi_we    <= 1'b1;
        lo_we    <= 1'b1;
      end
      if (commit) begin
        if (hi_we) hi <= pend_hi;
        if (lo_we) lo <= pend_lo;
      end
    end
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised HI/LO multiply/divide unit for the execute stage, replacing fixed-width vendor-IP multiply/divide with in-house iterative logic. Accepts one HI/LO-class instruction at a time through a valid/ready handshake and returns a result through a second handshake. Commits HI/LO only when the result is consumed, so the pipeline can suppress it or flush it.

## Interface
- `XLEN`, 32: operand, HI and LO width.
- `MUL_STAGES`, 3: multiply latency in cycles, minimum 1. The multiplier is retimed across this many register stages.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `flush` in 1: pipeline flush. Aborts any operation in flight.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit idle and can accept. Reset value 1.
- `op` in `hilo_op_e`: operation code.
- `src1`, `src2` in `XLEN`: operands.
- `wr_disable` in 1: blocks the HI/LO commit. Sampled at the output handshake.
- `out_valid` out 1: result available. Reset value 0.
- `out_ready` in 1: consumer accepts the result.
- `result` out `XLEN`: GPR-bound result. Reset value 0.
- `hi`, `lo` out `XLEN`: architectural HI and LO registers. Reset value 0.

## Operation
- The FSM has four states: IDLE, MUL, DIV, DONE.
- `in_ready` = (state == IDLE).
- An operation is accepted when `in_valid && in_ready && !flush`. Operands and op are latched on accept.
- Routing out of IDLE on accept:
  - MTHI, MTLO, MFHI, MFLO go to DONE.
  - MULT, MULTU, MUL, MADD, MADDU, MSUB, MSUBU go to MUL.
  - DIV, DIVU go to DIV.
- Multiply:
  - Signed ops (MULT, MUL, MADD, MSUB) multiply 2·XLEN-bit sign-extended operands. Unsigned ops zero-extend.
  - MADD/MADDU compute {hi,lo} + prod. MSUB/MSUBU compute {hi,lo} − prod. Both are modulo 2^(2·XLEN).
  - The accumulate uses the hi/lo values present at completion.
- Divide:
  - Restoring radix-2, one quotient bit per cycle, performed on magnitudes. The first cycle takes absolute values, then XLEN iteration cycles, then one fix-up cycle.
  - Signed quotient is negated when the operand signs differ. Signed remainder takes the sign of the dividend.
  - Divide by zero, both signed and unsigned: quotient = all ones, remainder = src1. Latency is unchanged.
- Results written on commit:
  - DIV/DIVU: lo ← quotient, hi ← remainder; `result` = quotient.
  - MULT/MADD family: {hi,lo} ← 2·XLEN value; `result` = low XLEN bits.
  - MUL: `result` = low XLEN bits of the product; HI and LO are not modified.
  - MTHI/MTLO: `result` = src1; the matching register ← src1.
  - MFHI/MFLO: `result` = hi or lo as it stands at accept.
- In DONE, `out_valid` = 1 and `result` is held stable until the handshake.
- On `out_valid && out_ready`:
  - HI/LO are written if `!wr_disable`.
  - The FSM returns to IDLE.
  - A new op is accepted no earlier than the next cycle, so back-to-back MADD sees the committed HI/LO.
- `flush` forces IDLE next cycle from any state and drops `out_valid`. No HI/LO write occurs, even if a handshake is present in the same cycle. `flush` also wins over a simultaneous accept.
- `reset` clears the state to IDLE, hi = lo = 0, `result` = 0, `out_valid` = 0, and the divider and multiplier valid pipes.

## Timing
- Accept edge = cycle 0. `out_valid` rises at:
  - MT/MF: cycle 1.
  - Multiply ops: cycle MUL_STAGES.
  - DIV/DIVU: cycle XLEN+2.
- With `out_ready` held high the result is consumed on that first `out_valid` cycle. `in_ready` returns one cycle later.
- `hi`/`lo` update on the clock edge of the output handshake and are visible the following cycle.
- Throughput: at most one operation per (latency + 1) cycles.
- A stalled consumer holds DONE indefinitely with no state change.

## Structure
- Package `hilo_pkg` holds:
  - `hilo_op_e`, a 4-bit enum: MTHI, MTLO, MFHI, MFLO, DIV, DIVU, MULT, MULTU, MUL, MADD, MADDU, MSUB, MSUBU.
  - The FSM state enum.
  - Helper functions `is_signed_op`, `is_mul_op`, `writes_hilo`.
- Sub-module `div_iter`:
  - Parameter XLEN.
  - Ports: start/busy/done, magnitude dividend/divisor in, quotient/remainder out.
  - Accepts a `flush`-driven abort.
- The multiplier stays inline as a MUL_STAGES-deep registered product pipe.

## Test plan
1. MULT src1=0xFFFFFFFF, src2=0x00000002 → `out_valid` at cycle 3; hi=0xFFFFFFFF, lo=0xFFFFFFFE, `result`=0xFFFFFFFE.
2. DIV src1=0xFFFFFFF9 (−7), src2=2 → `out_valid` at cycle 34; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands → lo=0x7FFFFFFC, hi=1.
3. DIVU src1=5, src2=0 → lo=0xFFFFFFFF, hi=5, at cycle 34.
4. MTHI 0x12345678, MTLO 0, then MADDU 0x10000×0x10000 → hi=0x12345679, lo=0. Then MSUBU with the same operands → hi=0x12345678.
5. Flush at cycle 10 of a DIV → `in_ready` high next cycle; hi/lo unchanged; a following MFLO returns the prior lo.
6. MULTU 3×4 with `wr_disable`=1 at the handshake → `result`=12, hi/lo unchanged. MUL 3×4 → `result`=12, hi/lo unchanged.
